// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC and reads each 2-byte instruction from a
// registered byte-wide ROM. It presents the instruction to the CPU through a valid/ready
// handshake and handles jump redirects and the halt opcode.
// Optional build macro FETCH_SKIP_NOP_EN: nop instructions (opcode1 == 8'h00) are fetched
// but never presented to the CPU.
module instr_fetch_seq #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] HALT_OP  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  output logic [7:0] opcode1,
  output logic [7:0] opcode2,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       jump_valid,
  input  logic [7:0] jump_target,
  output logic [7:0] pc_out,
  output logic       halted
);

  localparam logic [7:0] NOP_OP = 8'h00;

`ifdef FETCH_SKIP_NOP_EN
  localparam logic SKIP_NOP = 1'b1;
`else
  localparam logic SKIP_NOP = 1'b0;
`endif

  typedef enum logic [2:0] {
    F1     = 3'd0,
    F2     = 3'd1,
    F3     = 3'd2,
    VALID  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] byte0;

  // Fetch sequencing. rom_address is loaded on entry to F1 and F2 so that it is already
  // stable during those states. opcode1, opcode2 and pc_out are updated only on entry to VALID.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= F1;
      pc          <= RESET_PC;
      rom_address <= RESET_PC;
      byte0       <= 8'h00;
      opcode1     <= 8'h00;
      opcode2     <= 8'h00;
      pc_out      <= RESET_PC;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (jump_valid) begin
      state       <= F1;
      pc          <= jump_target;
      rom_address <= jump_target;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        F1: begin
          rom_address <= 8'(pc + 8'd1);
          state       <= F2;
        end
        F2: begin
          byte0 <= rom_data;
          state <= F3;
        end
        F3: begin
          pc <= 8'(pc + 8'd2);
          if (SKIP_NOP && (byte0 == NOP_OP)) begin
            rom_address <= 8'(pc + 8'd2);
            state       <= F1;
          end else begin
            opcode1     <= byte0;
            opcode2     <= rom_data;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (opcode1 == HALT_OP) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              rom_address <= pc;
              state       <= F1;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          rom_address <= pc;
          instr_valid <= 1'b0;
          state       <= F1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Testbench for instr_fetch_seq. A scoreboard queue holds the instruction that is expected
// next, a negedge monitor checks the outputs against it, and a directed + random driver
// supplies the stimulus.
module tb_instr_fetch_seq;

  localparam logic [7:0] RESET_PC = 8'h00;
  localparam logic [7:0] HALT_OP  = 8'hFF;

`ifdef FETCH_SKIP_NOP_EN
  localparam int NOP_FIRST_CYCLE = 7;
`else
  localparam int NOP_FIRST_CYCLE = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_ready = 1'b0;
  logic       jump_valid = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic [7:0] rom_address, rom_data, opcode1, opcode2, pc_out;
  logic       instr_valid, halted;

  logic [7:0] rom [256];

  typedef struct {
    logic [7:0] op1;
    logic [7:0] op2;
    logic [7:0] pc;
  } instr_t;

  instr_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  bit     expect_halt = 1'b0;
  bit     prev_hold = 1'b0;
  int     idle_cycles = 0;

  always #5 clk = ~clk;

  // Registered ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom[rom_address];

  instr_fetch_seq #(.RESET_PC(RESET_PC), .HALT_OP(HALT_OP)) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .opcode1     (opcode1),
    .opcode2     (opcode2),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .pc_out      (pc_out),
    .halted      (halted)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Next instruction the CPU should see when execution continues from pc.
  function automatic instr_t predict(input logic [7:0] pc);
    instr_t     t;
    logic [7:0] p;
    p = pc;
`ifdef FETCH_SKIP_NOP_EN
    for (int i = 0; i < 128 && rom[p] == 8'h00; i++) p = 8'(p + 8'd2);
`endif
    t.op1 = rom[p];
    t.op2 = rom[8'(p + 8'd1)];
    t.pc  = p;
    return t;
  endfunction

  task automatic restart(input logic [7:0] target);
    exp_q.delete();
    exp_q.push_back(predict(target));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset for one edge and check the reset values; the caller edits the ROM, then releases.
  task automatic reset_on();
    reset = 1'b1;
    jump_valid = 1'b0;
    tick();
    check("rst_rom_address", rom_address, RESET_PC);
    check("rst_opcode1", opcode1, 8'h00);
    check("rst_opcode2", opcode2, 8'h00);
    check("rst_valid", instr_valid, 8'h00);
    check("rst_pc_out", pc_out, RESET_PC);
    check("rst_halted", halted, 8'h00);
  endtask

  task automatic reset_off();
    reset = 1'b0;
    restart(RESET_PC);
  endtask

  task automatic jump(input logic [7:0] target);
    jump_valid  = 1'b1;
    jump_target = target;
    restart(target);
    tick();
    jump_valid = 1'b0;
  endtask

  task automatic expect_valid_in(input string name, input int cycles);
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      check(name, instr_valid, (c == cycles) ? 8'h01 : 8'h00);
    end
  endtask

  // Monitor: compares every presented instruction with the scoreboard head, and advances
  // the model on each accepted instruction.
  always @(negedge clk) begin
    instr_t t;
    if (reset || jump_valid) begin
      expect_halt = 1'b0;
      prev_hold   = 1'b0;
      idle_cycles = 0;
    end else begin
      if (prev_hold) check("valid_held", instr_valid, 8'h01);
      if (expect_halt) begin
        check("halt_flag", halted, 8'h01);
        check("halt_valid", instr_valid, 8'h00);
      end else if (instr_valid) begin
        idle_cycles = 0;
        check("halted_low", halted, 8'h00);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", instr_valid, 8'h00);
        end else begin
          t = exp_q[0];
          check("opcode1", opcode1, t.op1);
          check("opcode2", opcode2, t.op2);
          check("pc_out", pc_out, t.pc);
          if (instr_ready) begin
            void'(exp_q.pop_front());
            if (t.op1 == HALT_OP) expect_halt = 1'b1;
            else exp_q.push_back(predict(8'(t.pc + 8'd2)));
          end
        end
      end else begin
        idle_cycles++;
        if (idle_cycles == 40) check("fetch_timeout", instr_valid, 8'h01);
      end
      prev_hold = (instr_valid === 1'b1) && !instr_ready;
    end
  end

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) rom[i] = 8'(8'h01 + ($urandom % 8'hFD));

    // Basic latency, ready held low in VALID, then the back-to-back fetch and a jump in F2.
    reset_on();
    rom[0] = 8'h10; rom[1] = 8'hFF; rom[2] = 8'h22; rom[3] = 8'h0F;
    rom[8'h40] = 8'h33; rom[8'h41] = 8'h83;
    reset_off();
    instr_ready = 1'b0;
    expect_valid_in("first_latency", 4);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", instr_valid, 8'h01);
      check("stall_rom_address", rom_address, 8'h01);
    end
    tick();
    instr_ready = 1'b1;
    @(negedge clk);
    expect_valid_in("second_latency", 4);
    tick();
    tick();
    jump(8'h40);
    expect_valid_in("jump_latency", 4);
    repeat (6) tick();

    // PC wrap: start at FF.
    reset_on();
    rom[8'hFF] = 8'h10; rom[0] = 8'hAB;
    reset_off();
    jump(8'hFF);
    expect_valid_in("wrap_latency", 4);
    repeat (12) tick();

    // Halt at 06, then resume with a jump.
    reset_on();
    for (int i = 0; i < 6; i++) rom[i] = 8'(8'h10 + i);
    rom[6] = HALT_OP;
    reset_off();
    instr_ready = 1'b1;
    repeat (22) tick();
    repeat (12) begin
      @(negedge clk);
      check("halted_stay", halted, 8'h01);
      check("halted_valid", instr_valid, 8'h00);
      check("halted_rom_address", rom_address, 8'h07);
    end
    tick();
    jump(8'h00);
    @(negedge clk);
    check("resume_halted", halted, 8'h00);
    repeat (10) tick();

    // Nop at the reset PC, then reset while an instruction is waiting.
    reset_on();
    rom[0] = 8'h00; rom[1] = 8'h77; rom[2] = 8'h10; rom[3] = 8'h05;
    reset_off();
    instr_ready = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 12 && cyc == 0; c++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) cyc = c;
    end
    check("nop_first_cycle", 8'(cyc), 8'(NOP_FIRST_CYCLE));
    tick();
    reset_on();

    // Random traffic with random jumps and occasional halt opcodes.
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom);
      if ($urandom % 24 == 0) rom[i] = HALT_OP;
    end
    reset_off();
    for (int n = 0; n < 4000; n++) begin
      tick();
      instr_ready = ($urandom % 4) != 0;
      if ($urandom % 24 == 0) begin
        jump_valid  = 1'b1;
        jump_target = 8'($urandom);
        restart(jump_target);
      end else begin
        jump_valid = 1'b0;
      end
    end
    tick();
    jump_valid  = 1'b0;
    instr_ready = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
